// File: rtl/spi_target_pkg.sv
// Shared types for the SPI target.
//   state_e          : controller FSM states
//   MODE0..MODE3     : SPI mode numbers, bit 1 = CPOL, bit 0 = CPHA
//   mode_cpol/cpha() : split a mode number into its clock polarity and phase
package spi_target_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } state_e;

    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser and edge detector for one asynchronous SPI pin.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d_in       : raw pin
//   d_s        : synchronised level (after SYNC_STAGES flops)
//   d_rise     : 1-clk pulse when d_s goes 0 -> 1
//   d_fall     : 1-clk pulse when d_s goes 1 -> 0
// RESET_VAL is the pin's idle level so that leaving reset does not
// look like an edge.
module spi_sync_edge
    import spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_s,
    output logic d_rise,
    output logic d_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign d_s    = sync_q[SYNC_STAGES-1];
    assign d_rise = d_s & ~prev_q;
    assign d_fall = ~d_s & prev_q;

endmodule

// File: rtl/spi_target_word.sv
// SPI target with DATA_W-bit words, all four CPOL/CPHA modes and
// back-to-back words while chip select stays low. The pins are
// oversampled in the clk domain (SCLK <= clk/4).
//   clk, rst_n              : system clock, asynchronous active-low reset
//   spi_cs_n/sclk/mosi      : asynchronous SPI pins from the controller
//   spi_miso, spi_miso_oe   : target data and its output enable
//   tx_data/valid/ready     : one-word TX holding register (valid/ready)
//   rx_data/valid/ready     : last received word, held until accepted
//   rx_overrun              : pulse, word completed while rx_valid was set
//   tx_underrun             : pulse, word started without a TX word
//   frame_abort             : pulse, chip select rose mid-word
//   busy                    : FSM not idle
module spi_target_word
    import spi_target_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] DEFAULT_TX  = 32'hA9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic              busy
);

    localparam int                CNT_W        = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX     = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] DEFAULT_WORD = DEFAULT_TX[DATA_W-1:0];

    // Bit-order helpers: the word is always consumed/filled from the
    // end selected by MSB_FIRST.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                   input logic b);
        return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d_in(spi_cs_n),
        .d_s(cs_s), .d_rise(cs_rise), .d_fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_in(spi_sclk),
        .d_s(sclk_s), .d_rise(sclk_rise), .d_fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_in(spi_mosi),
        .d_s(mosi_s), .d_rise(mosi_rise), .d_fall(mosi_fall)
    );

    assign unused_edges = mosi_rise ^ mosi_fall ^ cs_rise;

    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]  rx_sr_q, rx_sr_d;
    logic               miso_q, miso_d;
    logic               word_done_q, word_done_d;
    logic               underrun_pend_q, underrun_pend_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_overrun_q, rx_overrun_d;
    logic               tx_underrun_q, tx_underrun_d;
    logic               frame_abort_q, frame_abort_d;
    logic [DATA_W-1:0]  load_word;

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        tx_sr_d         = tx_sr_q;
        rx_sr_d         = rx_sr_q;
        miso_d          = miso_q;
        word_done_d     = 1'b0;
        underrun_pend_d = underrun_pend_q;
        hold_d          = hold_q;
        hold_full_d     = hold_full_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = rx_valid_q;
        rx_overrun_d    = 1'b0;
        tx_underrun_d   = 1'b0;
        frame_abort_d   = 1'b0;
        load_word       = hold_q;

        // TX holding register accept. While full it cannot accept, so
        // this never collides with LOAD emptying it.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        // RX output register: an accept in the same cycle as a
        // completion frees the slot for the new word.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (word_done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end

        if (cs_s) begin
            // Deselect wins over everything. Only XFER can hold a partial
            // word; bit_cnt is 0 there right after a word boundary.
            if (state_q == XFER && bit_cnt_q != '0) begin
                frame_abort_d = 1'b1;
            end
            state_d         = IDLE;
            bit_cnt_d       = '0;
            miso_d          = 1'b1;
            underrun_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (hold_full_q) begin
                        hold_full_d     = 1'b0;
                        underrun_pend_d = 1'b0;
                    end else begin
                        load_word       = DEFAULT_WORD;
                        underrun_pend_d = 1'b1;
                    end
                    if (!CPHA) begin
                        miso_d  = first_bit(load_word);
                        tx_sr_d = shift_out(load_word);
                    end else begin
                        tx_sr_d = load_word;
                    end
                    bit_cnt_d = '0;
                    state_d   = XFER;
                end
                XFER: begin
                    // With CPHA=0 the shift edge seen at bit_cnt=0 is the
                    // tail edge of the previous word; the next word's first
                    // bit is already on the pin from LOAD.
                    if (shift_edge && (CPHA || bit_cnt_q != '0)) begin
                        miso_d  = first_bit(tx_sr_q);
                        tx_sr_d = shift_out(tx_sr_q);
                    end
                    if (sample_edge) begin
                        // An underrun only counts once the controller
                        // actually clocks the word, so the trailing LOAD
                        // before a deselect stays silent.
                        if (bit_cnt_q == '0) begin
                            tx_underrun_d   = underrun_pend_q;
                            underrun_pend_d = 1'b0;
                        end
                        rx_sr_d   = shift_in(rx_sr_q, mosi_s);
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_IDX) begin
                            word_done_d = 1'b1;
                            state_d     = LOAD;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            tx_sr_q         <= '0;
            rx_sr_q         <= '0;
            miso_q          <= 1'b1;
            word_done_q     <= 1'b0;
            underrun_pend_q <= 1'b0;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_overrun_q    <= 1'b0;
            tx_underrun_q   <= 1'b0;
            frame_abort_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            tx_sr_q         <= tx_sr_d;
            rx_sr_q         <= rx_sr_d;
            miso_q          <= miso_d;
            word_done_q     <= word_done_d;
            underrun_pend_q <= underrun_pend_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            rx_overrun_q    <= rx_overrun_d;
            tx_underrun_q   <= tx_underrun_d;
            frame_abort_q   <= frame_abort_d;
        end
    end

    assign spi_miso    = cs_s ? 1'b1 : miso_q;
    assign spi_miso_oe = ~cs_s;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;
    assign busy        = (state_q != IDLE);

endmodule
